// File: rtl/fetch_stage.sv
// Instruction fetch stage: keeps one instruction request outstanding and delivers words
// to decode. It holds on freeze, flushes on branch, and drains a redirected in-flight request.
module fetch_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] PC,
  output logic [31:0] Instruction_out
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_req_addr;
  logic [31:0] r_buf;
  logic [31:0] r_pc_out;
  logic [31:0] r_instr_out;
  logic [31:0] w_pc_plus4;

  assign w_pc_plus4      = r_pc + 32'd4;
  assign imem_req        = (r_state != S_HOLD);
  assign imem_addr       = r_req_addr;
  assign PC              = r_pc_out;
  assign Instruction_out = r_instr_out;

  // NOTE: all state uses non-blocking assignments so every branch of the case reads the
  // pre-edge values of r_pc and r_state, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: r_buf is an ordinary flop, not a memory array, so it is cleared with the rest;
      // a held word must never survive a reset.
      r_state     <= S_REQ;
      r_pc        <= 32'h0;
      r_req_addr  <= 32'h0;
      r_buf       <= 32'h0;
      r_pc_out    <= 32'h0;
      r_instr_out <= 32'h0;
    end else begin
      case (r_state)
        S_REQ: begin
          if (branch_taken) begin
            r_pc        <= branch_addr;
            r_pc_out    <= 32'h0;
            r_instr_out <= 32'h0;
            if (imem_ack) begin
              r_req_addr <= branch_addr;
            end else begin
              // The old request is still in flight; its data must be drained and dropped.
              r_state <= S_DRAIN;
            end
          end else if (imem_ack) begin
            if (freeze) begin
              r_buf   <= imem_rdata;
              r_state <= S_HOLD;
            end else begin
              r_pc_out    <= w_pc_plus4;
              r_instr_out <= imem_rdata;
              r_pc        <= w_pc_plus4;
              r_req_addr  <= w_pc_plus4;
            end
          end else if (!freeze) begin
            r_pc_out    <= 32'h0;
            r_instr_out <= 32'h0;
          end
        end

        S_HOLD: begin
          if (branch_taken) begin
            r_pc        <= branch_addr;
            r_req_addr  <= branch_addr;
            r_pc_out    <= 32'h0;
            r_instr_out <= 32'h0;
            r_state     <= S_REQ;
          end else if (!freeze) begin
            r_pc_out    <= w_pc_plus4;
            r_instr_out <= r_buf;
            r_pc        <= w_pc_plus4;
            r_req_addr  <= w_pc_plus4;
            r_state     <= S_REQ;
          end
        end

        S_DRAIN: begin
          if (branch_taken) begin
            r_pc        <= branch_addr;
            r_pc_out    <= 32'h0;
            r_instr_out <= 32'h0;
            if (imem_ack) begin
              r_req_addr <= branch_addr;
              r_state    <= S_REQ;
            end
          end else begin
            if (!freeze) begin
              r_pc_out    <= 32'h0;
              r_instr_out <= 32'h0;
            end
            if (imem_ack) begin
              r_req_addr <= r_pc;
              r_state    <= S_REQ;
            end
          end
        end

        default: r_state <= S_REQ;
      endcase
    end
  end

endmodule
